wb_cmd_initiator: RTL and testbench

// Wishbone classic single-cycle bus initiator in FPGA fabric: buffers commands from a producer
// (UART bridge, sequencer, test harness) and drives them onto fabric-side WB register slaves.

---
 rtl/wb_cmd_initiator.sv | 145 ++++++++++++++
 tb/tb_wb_cmd_initiator.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator: Wishbone classic single-cycle bus initiator fed from a command FIFO.
// Each queued command becomes one WB cycle and returns exactly one response on a valid/ready port.
// Optional feature macro: WB_INIT_TIMEOUT_EN aborts a bus cycle that sees no ack within TIMEOUT
// cycles and reports it with o_rsp_err=1 and o_rsp_dat=32'hDEADBEEF.
module wb_cmd_initiator #(
  parameter int unsigned ADR_W     = 17,
  parameter int unsigned DAT_W     = 32,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [ADR_W-1:0] i_cmd_adr,
  input  logic [DAT_W-1:0] i_cmd_dat,
  input  logic             i_cmd_wen,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [DAT_W-1:0] o_rsp_dat,
  output logic             o_rsp_err,
  output logic [ADR_W-1:0] o_wb_adr,
  output logic [DAT_W-1:0] o_wb_dat,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_wen,
  input  logic [DAT_W-1:0] i_wb_dat,
  input  logic             i_wb_ack,
  output logic             o_busy
);

  localparam int unsigned PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADR_W + DAT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t           state;
  logic [ENT_W-1:0] mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  assign full        = (count == CNT_W'(CMD_DEPTH));
  assign empty       = (count == '0);
  assign push        = i_cmd_valid & ~full;
  assign pop         = (state == S_IDLE) & ~empty;
  assign head        = mem[rd_ptr];
  assign o_cmd_ready = ~full;
  assign o_wb_stb    = o_wb_cyc;
  assign o_busy      = ~empty | (state != S_IDLE);

  // Command storage: written on push, no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {i_cmd_adr, i_cmd_dat, i_cmd_wen};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef WB_INIT_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TO_W-1:0] to_cnt;
`endif

  // Bus FSM: IDLE pops a command, BUS holds the WB cycle until ack, RESP holds the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      o_wb_cyc    <= 1'b0;
      o_wb_adr    <= '0;
      o_wb_dat    <= '0;
      o_wb_wen    <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_dat   <= '0;
      o_rsp_err   <= 1'b0;
`ifdef WB_INIT_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            {o_wb_adr, o_wb_dat, o_wb_wen} <= head;
            o_wb_cyc <= 1'b1;
            state    <= S_BUS;
`ifdef WB_INIT_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
        end
        S_BUS: begin
          if (i_wb_ack) begin
            o_wb_cyc    <= 1'b0;
            o_rsp_dat   <= o_wb_wen ? '0 : i_wb_dat;
            o_rsp_err   <= 1'b0;
            o_rsp_valid <= 1'b1;
            state       <= S_RESP;
          end
`ifdef WB_INIT_TIMEOUT_EN
          // Abort on the edge where the count would reach TIMEOUT; ack on that edge wins above.
          else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            o_wb_cyc    <= 1'b0;
            o_rsp_dat   <= DAT_W'(32'hDEADBEEF);
            o_rsp_err   <= 1'b1;
            o_rsp_valid <= 1'b1;
            state       <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// tb_wb_cmd_initiator: directed tests for wb_cmd_initiator against a behavioural WB register slave.
// Build with WB_INIT_TIMEOUT_EN defined to include the timeout scenario (TIMEOUT=16).
module tb_wb_cmd_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [16:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic        cmd_wen = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic [16:0] wb_adr;
  logic [31:0] wb_dat;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_wen;
  logic [31:0] wb_rdat;
  logic        wb_ack;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_cmd_initiator #(
    .ADR_W(17), .DAT_W(32), .CMD_DEPTH(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat), .i_cmd_wen(cmd_wen),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_dat(rsp_dat), .o_rsp_err(rsp_err),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb),
    .o_wb_wen(wb_wen), .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack), .o_busy(busy)
  );

  // Register slave: ack once cyc&stb has been seen for slv_wait extra cycles, optional trailing ack.
  logic [31:0] regs [16];
  int unsigned slv_wait = 0;
  logic        slv_mute = 1'b0;
  logic        slv_trail = 1'b0;
  int unsigned wcnt = 0;
  logic        slv_ack_c;
  logic        trail_r = 1'b0;
  logic [3:0]  sidx;

  assign sidx      = wb_adr[5:2];
  assign slv_ack_c = wb_cyc & wb_stb & ~slv_mute & (wcnt == slv_wait);
  assign wb_ack    = slv_ack_c | trail_r;
  assign wb_rdat   = regs[sidx];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
      regs[2] <= 32'hA5A5A5A5;
      for (int k = 0; k < 5; k++) regs[4+k] <= 32'h1111_0000 + k;
      wcnt    <= 0;
      trail_r <= 1'b0;
    end else begin
      trail_r <= slv_trail & slv_ack_c;
      if (wb_cyc & wb_stb & ~slv_ack_c) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (slv_ack_c & wb_wen) regs[sidx] <= wb_dat;
    end
  end

  // Observers sampled mid-cycle: cyc occupancy, stb/cyc equality, bus stability, response log.
  int          cyc_cycles = 0;
  int          stb_err = 0;
  int          stab_err = 0;
  int          total_rsp = 0;
  logic        prev_cyc = 1'b0;
  logic [49:0] prev_bus = '0;
  logic [32:0] rsp_q [$];

  always @(negedge clk) begin
    if (wb_cyc) cyc_cycles++;
    if (wb_stb !== wb_cyc) stb_err++;
    if (wb_cyc && prev_cyc && ({wb_adr, wb_dat, wb_wen} !== prev_bus)) stab_err++;
    prev_cyc = wb_cyc;
    prev_bus = {wb_adr, wb_dat, wb_wen};
    if (rsp_valid && rsp_ready) begin
      rsp_q.push_back({rsp_err, rsp_dat});
      total_rsp++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [16:0] a, input logic [31:0] d, input logic w);
    int n = 0;
    while (!cmd_ready && n < 200) begin step(); n++; end
    if (!cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL push_wait: cmd_ready=%b, required 1 within 200 cycles", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_adr = a; cmd_dat = d; cmd_wen = w;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [32:0] r);
    int n = 0;
    while (rsp_q.size() == 0 && n < 300) begin step(); n++; end
    if (rsp_q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL rsp_wait: no response, required one within 300 cycles");
      r = 'x;
    end else begin
      r = rsp_q.pop_front();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || rsp_valid) && n < 300) begin step(); n++; end
    if (busy || rsp_valid) begin
      vectors++; miscompares++;
      $display("FAIL idle_wait: busy=%b rsp_valid=%b, required 0/0 within 300 cycles", busy, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (wb_cyc !== 1'b0) begin miscompares++; $display("FAIL reset_cyc: got %b want 0", wb_cyc); end
    vectors++; if (wb_stb !== 1'b0) begin miscompares++; $display("FAIL reset_stb: got %b want 0", wb_stb); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (rsp_dat !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_dat: got %h want 0", rsp_dat); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    vectors++; if ({wb_adr, wb_dat, wb_wen} !== 50'h0) begin miscompares++; $display("FAIL reset_wb_bus: got %h want 0", {wb_adr, wb_dat, wb_wen}); end
  endtask

  task automatic test_write_read();
    logic [32:0] r0, r1;
    int base;
    rsp_ready = 1'b1;
    base = cyc_cycles;
    push(17'h0, 32'h0000_1000, 1'b1);
    push(17'h0, 32'hFFFF_FFFF, 1'b0);
    get_rsp(r0);
    get_rsp(r1);
    wait_idle();
    vectors++; if (r0 !== {1'b0, 32'h0}) begin miscompares++; $display("FAIL wr_rsp: got %h want 0_00000000", r0); end
    vectors++; if (r1 !== {1'b0, 32'h0000_1000}) begin miscompares++; $display("FAIL rd_rsp: got %h want 0_00001000", r1); end
    vectors++; if (cyc_cycles - base !== 2) begin miscompares++; $display("FAIL wr_rd_cyc_cycles: got %0d want 2", cyc_cycles - base); end
    vectors++; if (stb_err !== 0) begin miscompares++; $display("FAIL stb_eq_cyc: got %0d differing cycles want 0", stb_err); end
  endtask

  task automatic test_fifo_full();
    logic [32:0] r, exp;
    int base;
    rsp_ready = 1'b0;
    base = cyc_cycles;
    for (int k = 0; k < 5; k++) push(17'((4 + k) * 4), 32'h0, 1'b0);
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
    repeat (3) step();
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_held: got %b want 0", cmd_ready); end
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL full_rsp_valid: got %b want 1", rsp_valid); end
    vectors++; if (rsp_dat !== 32'h1111_0000) begin miscompares++; $display("FAIL full_rsp_hold: got %h want 11110000", rsp_dat); end
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      get_rsp(r);
      exp = {1'b0, 32'h1111_0000 + 32'(k)};
      vectors++; if (r !== exp) begin miscompares++; $display("FAIL fifo_order[%0d]: got %h want %h", k, r, exp); end
    end
    wait_idle();
    vectors++; if (rsp_q.size() !== 0) begin miscompares++; $display("FAIL fifo_extra_rsp: got %0d extra want 0", rsp_q.size()); end
    vectors++; if (cyc_cycles - base !== 5) begin miscompares++; $display("FAIL fifo_cyc_cycles: got %0d want 5", cyc_cycles - base); end
  endtask

  task automatic test_wait_states();
    logic [32:0] r;
    int base, stab0;
    slv_wait = 3;
    rsp_ready = 1'b1;
    base = cyc_cycles;
    stab0 = stab_err;
    push(17'h8, 32'h0, 1'b0);
    get_rsp(r);
    wait_idle();
    slv_wait = 0;
    vectors++; if (r !== {1'b0, 32'hA5A5_A5A5}) begin miscompares++; $display("FAIL ws_rsp: got %h want 0_a5a5a5a5", r); end
    vectors++; if (cyc_cycles - base !== 4) begin miscompares++; $display("FAIL ws_cyc_cycles: got %0d want 4", cyc_cycles - base); end
    vectors++; if (stab_err !== stab0) begin miscompares++; $display("FAIL ws_bus_stable: got %0d changes want 0", stab_err - stab0); end
  endtask

`ifdef WB_INIT_TIMEOUT_EN
  task automatic test_timeout();
    logic [32:0] r0, r1;
    int base, mid;
    slv_mute = 1'b1;
    rsp_ready = 1'b1;
    base = cyc_cycles;
    push(17'h8, 32'h0, 1'b0);
    push(17'h0, 32'h0, 1'b0);
    get_rsp(r0);
    slv_mute = 1'b0;
    mid = cyc_cycles - base;
    get_rsp(r1);
    wait_idle();
    vectors++; if (r0 !== {1'b1, 32'hDEAD_BEEF}) begin miscompares++; $display("FAIL to_rsp: got %h want 1_deadbeef", r0); end
    vectors++; if (mid !== 16) begin miscompares++; $display("FAIL to_cyc_cycles: got %0d want 16", mid); end
    vectors++; if (r1 !== {1'b0, 32'h0000_1000}) begin miscompares++; $display("FAIL to_next_rsp: got %h want 0_00001000", r1); end
  endtask
`endif

  task automatic test_reset_in_bus();
    int base, rsp0;
    slv_mute = 1'b1;
    rsp_ready = 1'b1;
    base = cyc_cycles;
    rsp0 = total_rsp;
    push(17'h0, 32'h0, 1'b0);
    push(17'h8, 32'h0, 1'b0);
    push(17'h10, 32'h0, 1'b0);
    vectors++; if (wb_cyc !== 1'b1) begin miscompares++; $display("FAIL rb_in_bus: got cyc=%b want 1", wb_cyc); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++; if (wb_cyc !== 1'b0) begin miscompares++; $display("FAIL rb_cyc: got %b want 0", wb_cyc); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rb_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rb_busy: got %b want 0", busy); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rb_cmd_ready: got %b want 1", cmd_ready); end
    slv_mute = 1'b0;
    repeat (30) step();
    vectors++; if (total_rsp !== rsp0) begin miscompares++; $display("FAIL rb_no_rsp: got %0d responses want 0", total_rsp - rsp0); end
    vectors++; if (cyc_cycles - base !== 2) begin miscompares++; $display("FAIL rb_cyc_cycles: got %0d want 2", cyc_cycles - base); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rb_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_trailing_ack();
    logic [32:0] r0, r1;
    int base;
    slv_trail = 1'b1;
    slv_wait = 2;
    rsp_ready = 1'b1;
    base = cyc_cycles;
    push(17'h4, 32'h0000_0077, 1'b1);
    push(17'h4, 32'h0, 1'b0);
    get_rsp(r0);
    get_rsp(r1);
    wait_idle();
    slv_trail = 1'b0;
    slv_wait = 0;
    vectors++; if (r0 !== {1'b0, 32'h0}) begin miscompares++; $display("FAIL ta_wr_rsp: got %h want 0_00000000", r0); end
    vectors++; if (r1 !== {1'b0, 32'h0000_0077}) begin miscompares++; $display("FAIL ta_rd_rsp: got %h want 0_00000077", r1); end
    vectors++; if (cyc_cycles - base !== 6) begin miscompares++; $display("FAIL ta_cyc_cycles: got %0d want 6", cyc_cycles - base); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fifo_full();
    test_wait_states();
`ifdef WB_INIT_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_bus();
    test_trailing_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
